lsu_unit: RTL and testbench
===========================

// Module: lsu_unit
// PURPOSE
//  Load/store unit between the execute stage and the core's data-bus port (dreq/dresp).
//  - Accepts one memory op at a time over a valid/ready handshake.
//  - Drives a single dbus transaction: lane-shifts store data and builds byte strobes.
//  - Aligns and sign/zero-extends load data, then returns a tagged result to commit.
// PARAMETERS
//  TAG_W   5   width of the ROB tag carried with each op
//  DATA_W  64  bus/data width; only 64 is supported
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  flush        in   1       squash the op in flight (mispredict/exception)
//  req_valid    in   1       memory op offered by execute
//  req_ready    out  1       LSU can accept an op
//  req_store    in   1       1 = store, 0 = load
//  req_unsigned in   1       zero-extend load (LBU/LHU/LWU)
//  req_size     in   2       msize_t: 0=B 1=H 2=W 3=D
//  req_addr     in   64      effective address
//  req_wdata    in   64      store data, right-aligned
//  req_tag      in   TAG_W   ROB tag
//  dreq_valid   out  1       dbus request valid
//  dreq_addr    out  64      dbus address (unmodified req_addr)
//  dreq_size    out  2       dbus size
//  dreq_data    out  64      lane-shifted store data
//  dreq_strobe  out  8       byte strobe; 0 for loads
//  dresp_data   in   64      dbus read data, full doubleword
//  dresp_ok     in   1       dbus data_ok; completes the request
//  resp_valid   out  1       result available
//  resp_ready   in   1       commit consumes the result
//  resp_data    out  64      extended load data (0 for stores)
//  resp_tag     out  TAG_W   tag of the completed op
//  resp_exc     out  1       misaligned-access exception
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1 after reset; dreq_valid=0, resp_valid=0, resp_exc=0; data/tag regs=0.
//  - FSM IDLE -> BUS -> DONE -> IDLE.
//    - req_ready = (state==IDLE) & ~flush.
//    - Accept when req_valid & req_ready: capture all req_* fields, go to BUS.
//  - BUS: dreq_valid=1. dreq_* come only from the captured registers and stay stable until dresp_ok.
//    On dresp_ok: latch extended data, go to DONE.
//  - DONE: resp_valid=1. Go to IDLE on resp_ready. The next op can be accepted one cycle later.
//  - Minimum latency: accept edge -> resp_valid is 2 cycles, when dresp_ok arrives in the first BUS cycle.
//  - Strobe = {01,03,0F,FF}[size] << addr[2:0]. dreq_data = wdata << (8*addr[2:0]).
//  - Load: shift dresp_data right by 8*addr[2:0], truncate to size, then extend.
//    Sign-extend unless req_unsigned. Size D ignores req_unsigned.
//  - Flush in IDLE: no accept.
//  - Flush in BUS: set a killed flag.
//    - dreq_valid stays high until dresp_ok, because the bus may not abort a request.
//    - On dresp_ok go to IDLE with no resp_valid. The killed flag clears.
//  - Flush in DONE: drop the result and go to IDLE. Flush overrides resp_ready in the same cycle.
//  - A flush that is still high in the cycle the LSU returns to IDLE blocks acceptance in that cycle.
//  - Reset mid-op: return to IDLE at once. The interconnect is reset with the core, so the pending bus op is discarded.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   - An op with addr not a multiple of 2^size never enters BUS.
//   - Accept goes straight to DONE with resp_exc=1 and resp_data=req_addr (mtval).
//   - Flush in DONE drops it like any other result.
//  LSU_MISALIGN_TRAP_EN undefined:
//   - Misaligned ops are issued to the bus unchanged; strobe bits shifted past bit 7 are lost.
//   - resp_exc is tied to 0.
// STRUCTURE
//  - lsu_pkg: msize_t, lsu_state_t {IDLE,BUS,DONE}, lsu_req_t (captured op), lsu_resp_t.
//  - Strobe/shift/extend logic is a combinational sub-module lsu_align, reused by the LSU and the bench model.
//  - lsu_unit keeps the FSM, captured regs and killed flag.
// TESTING
//  - SD addr=0x80001000 wdata=0x1122334455667788, dresp_ok 1st BUS cycle
//    -> strobe=FF, data unchanged, resp_valid 2 cycles after accept, resp_data=0.
//  - SB addr=...1003 wdata=0xAB -> strobe=0x08, dreq_data=0x00000000AB000000.
//  - LB addr=...1005, dresp_data=0x0000_8000_0000_0000 (byte5=0x80) -> resp_data=0xFFFF_FFFF_FFFF_FF80.
//    Same op as LBU -> 0x80.
//  - LW, dresp_ok delayed 4 cycles, then flush while in BUS
//    -> dreq_valid held 4 cycles, then IDLE, no resp_valid, next op accepted.
//  - DONE with resp_ready=0 for 3 cycles -> resp_valid/data/tag stable, req_ready=0. resp_ready=1 -> IDLE next cycle.
//  - LH addr=...1001 with LSU_MISALIGN_TRAP_EN -> no dreq_valid, resp_exc=1, resp_data=addr.
//    Without the macro -> bus op issued, resp_exc=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op sizes, FSM states, captured
// request and registered response, plus the natural-alignment test used
// by the optional misaligned-access trap (LSU_MISALIGN_TRAP_EN).
package lsu_pkg;

  localparam int XLEN   = 64;
  localparam int STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Op as captured at accept; everything the bus phase needs.
  typedef struct packed {
    logic            store;
    logic            uns;
    msize_t          size;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            exc;
  } lsu_resp_t;

  // True when the address is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input msize_t size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purpose: byte-lane steering for the LSU (store shift + strobe, load align + extend).
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, outputs follow inputs.
// Ports:
//   size_i, unsigned_i  access size and zero-extend request
//   off_i               address bits [2:0], byte offset within the doubleword
//   wdata_i / wdata_o   right-aligned store data in, lane-shifted store data out
//   strobe_o            byte enables; bits shifted past lane 7 are dropped
//   rdata_i / rdata_o   raw bus doubleword in, aligned and extended load data out
import lsu_pkg::*;

module lsu_align (
  input  msize_t            size_i,
  input  logic              unsigned_i,
  input  logic [2:0]        off_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [STRB_W-1:0] strobe_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [STRB_W-1:0] base_strb;
  logic [XLEN-1:0]   rd_sh;
  logic [5:0]        bit_off;

  assign bit_off = {off_i, 3'b000};

  always_comb begin
    base_strb = 8'h00;
    case (size_i)
      SZ_B:    base_strb = 8'h01;
      SZ_H:    base_strb = 8'h03;
      SZ_W:    base_strb = 8'h0F;
      default: base_strb = 8'hFF;
    endcase
  end

  // 8-bit result: a misaligned access simply loses the upper strobe bits.
  assign strobe_o = base_strb << off_i;
  assign wdata_o  = wdata_i << bit_off;
  assign rd_sh    = rdata_i >> bit_off;

  always_comb begin
    rdata_o = rd_sh;
    case (size_i)
      SZ_B:    rdata_o = unsigned_i ? {56'd0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
      SZ_H:    rdata_o = unsigned_i ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
      SZ_W:    rdata_o = unsigned_i ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
      default: rdata_o = rd_sh;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Purpose: single-outstanding load/store unit between execute and the dbus port.
// Latency: accept cycle -> bus cycle(s) -> result cycle; 2 cycles minimum with an immediate dresp_ok.
// Backpressure: req_ready low while busy; result held in DONE until resp_ready (or flush).
// Ports:
//   clk, reset, flush          clock, sync active-high reset, squash of the op in flight
//   req_*                      op from execute (valid/ready)
//   dreq_* / dresp_*           dbus request held until dresp_ok
//   resp_*                     tagged result to commit (valid/ready)
// Build option: LSU_MISALIGN_TRAP_EN traps misaligned ops instead of issuing them.
import lsu_pkg::*;

module lsu_unit #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic              req_unsigned,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              dreq_valid,
  output logic [DATA_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [DATA_W-1:0] dreq_data,
  output logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dresp_data,
  input  logic              dresp_ok,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_exc
);

  lsu_state_t state_q, state_d;
  lsu_req_t   req_q, req_d;
  lsu_resp_t  resp_q, resp_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic       killed_q, killed_d;

  logic [STRB_W-1:0] strb;
  logic [XLEN-1:0]   st_data;
  logic [XLEN-1:0]   ld_data;

  // Steering always works from the captured op so dreq_* cannot move mid-request.
  lsu_align u_align (
    .size_i     (req_q.size),
    .unsigned_i (req_q.uns),
    .off_i      (req_q.addr[2:0]),
    .wdata_i    (req_q.wdata),
    .rdata_i    (dresp_data),
    .strobe_o   (strb),
    .wdata_o    (st_data),
    .rdata_o    (ld_data)
  );

  assign req_ready   = (state_q == IDLE) && !flush;
  assign dreq_valid  = (state_q == BUS);
  assign dreq_addr   = req_q.addr;
  assign dreq_size   = req_q.size;
  assign dreq_data   = st_data;
  assign dreq_strobe = req_q.store ? strb : 8'h00;
  // A flush in DONE drops the result, so it must not look consumable that cycle.
  assign resp_valid  = (state_q == DONE) && !flush;
  assign resp_data   = resp_q.data;
  assign resp_exc    = resp_q.exc;
  assign resp_tag    = tag_q;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    resp_d   = resp_q;
    tag_d    = tag_q;
    killed_d = killed_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d.store = req_store;
          req_d.uns   = req_unsigned;
          req_d.size  = msize_t'(req_size);
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          tag_d       = req_tag;
          killed_d    = 1'b0;
          state_d     = BUS;
`ifdef LSU_MISALIGN_TRAP_EN
          // Trapped ops skip the bus; the faulting address is reported as mtval.
          if (is_misaligned(req_addr[2:0], msize_t'(req_size))) begin
            resp_d.data = req_addr;
            resp_d.exc  = 1'b1;
            state_d     = DONE;
          end
`endif
        end
      end
      BUS: begin
        if (flush) begin
          killed_d = 1'b1;
        end
        // The bus cannot abort, so a killed op still waits for dresp_ok.
        if (dresp_ok) begin
          if (killed_q || flush) begin
            killed_d = 1'b0;
            state_d  = IDLE;
          end else begin
            resp_d.data = req_q.store ? '0 : ld_data;
            resp_d.exc  = 1'b0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (flush || resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      resp_q   <= '0;
      tag_q    <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      resp_q   <= resp_d;
      tag_q    <= tag_d;
      killed_q <= killed_d;
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: expected bus requests and results are queued
// at issue time; a negedge monitor pops and compares them as the DUT presents
// them. A responder process answers dreq after a programmable delay.
`timescale 1ns/1ps
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dresp_data;
  logic        dresp_ok;
  logic        resp_valid, resp_ready, resp_exc;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;

  int tests = 0;
  int fails = 0;
  int ok_delay = 0;
  int wcnt = 0;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [7:0]  strobe;
  } dexp_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        exc;
  } rexp_t;

  dexp_t dq[$];
  rexp_t rq[$];

  localparam logic [63:0] A = 64'h0000_0000_8000_1000;

  lsu_unit #(.TAG_W(5), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_unsigned(req_unsigned), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_data(dreq_data), .dreq_strobe(dreq_strobe),
    .dresp_data(dresp_data), .dresp_ok(dresp_ok),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_exc(resp_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bus responder: dresp_ok after ok_delay idle cycles of a live request.
  initial begin
    dresp_ok = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || !dreq_valid) begin
        dresp_ok = 1'b0;
        wcnt = 0;
      end else if (wcnt == ok_delay) begin
        dresp_ok = 1'b1;
        wcnt = 0;
      end else begin
        dresp_ok = 1'b0;
        wcnt++;
      end
    end
  end

  // Monitor: compares each new bus request and each consumed result.
  initial begin
    logic  dreq_prev;
    dexp_t de;
    rexp_t re;
    dreq_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        dreq_prev = 1'b0;
      end else begin
        if (dreq_valid && !dreq_prev) begin
          if (dq.size() == 0) begin
            chk("dreq_unexpected", 64'd1, 64'd0);
          end else begin
            de = dq.pop_front();
            chk("dreq_addr", dreq_addr, de.addr);
            chk("dreq_size", {62'd0, dreq_size}, {62'd0, de.size});
            chk("dreq_data", dreq_data, de.data);
            chk("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, de.strobe});
          end
        end
        dreq_prev = dreq_valid;
        if (resp_valid && resp_ready) begin
          if (rq.size() == 0) begin
            chk("resp_unexpected", 64'd1, 64'd0);
          end else begin
            re = rq.pop_front();
            chk("resp_data", resp_data, re.data);
            chk("resp_tag", {59'd0, resp_tag}, {59'd0, re.tag});
            chk("resp_exc", {63'd0, resp_exc}, {63'd0, re.exc});
          end
        end
      end
    end
  end

  // Queue expectations, present the op, return just after the accept edge.
  task automatic issue(input logic st, input logic uns, input logic [1:0] sz,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] tag,
                       input logic exp_bus, input logic [7:0] e_strb, input logic [63:0] e_dd,
                       input logic exp_resp, input logic [63:0] e_rd, input logic e_exc);
    dexp_t de;
    rexp_t re;
    if (exp_bus) begin
      de.addr = addr; de.size = sz; de.data = e_dd; de.strobe = e_strb;
      dq.push_back(de);
    end
    if (exp_resp) begin
      re.data = e_rd; re.tag = tag; re.exc = e_exc;
      rq.push_back(re);
    end
    req_store = st; req_unsigned = uns; req_size = sz;
    req_addr = addr; req_wdata = wd; req_tag = tag;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && !req_ready; i++) tick;
    chk("accept_ready", {63'd0, req_ready}, 64'd1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40 && !(req_ready && !resp_valid && !dreq_valid); i++) tick;
    chk("back_to_idle", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_store = 1'b0;
    req_unsigned = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    req_tag = '0; dresp_data = '0; resp_ready = 1'b1;
    repeat (3) tick;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_exc", {63'd0, resp_exc}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_tag", {59'd0, resp_tag}, 64'd0);
    reset = 1'b0;
    tick;

    // SD with immediate dresp_ok: result two cycles after the accept cycle.
    issue(1, 0, 2'd3, A, 64'h1122334455667788, 5'd1, 1, 8'hFF, 64'h1122334455667788, 1, 64'd0, 0);
    chk("lat_cycle1_no_resp", {63'd0, resp_valid}, 64'd0);
    tick;
    chk("lat_cycle2_resp", {63'd0, resp_valid}, 64'd1);
    wait_idle;

    issue(1, 0, 2'd0, A + 3, 64'hAB, 5'd2, 1, 8'h08, 64'h00000000AB000000, 1, 64'd0, 0);
    wait_idle;
    dresp_data = 64'h0000800000000000;
    issue(0, 0, 2'd0, A + 5, 64'd0, 5'd3, 1, 8'h00, 64'd0, 1, 64'hFFFFFFFFFFFFFF80, 0);
    wait_idle;
    issue(0, 1, 2'd0, A + 5, 64'd0, 5'd4, 1, 8'h00, 64'd0, 1, 64'h0000000000000080, 0);
    wait_idle;
    dresp_data = 64'h0000000080010000;
    issue(0, 0, 2'd1, A + 2, 64'd0, 5'd5, 1, 8'h00, 64'd0, 1, 64'hFFFFFFFFFFFF8001, 0);
    wait_idle;
    dresp_data = 64'hDEADBEEF00000000;
    issue(0, 1, 2'd2, A + 4, 64'd0, 5'd6, 1, 8'h00, 64'd0, 1, 64'h00000000DEADBEEF, 0);
    wait_idle;
    issue(0, 0, 2'd2, A + 4, 64'd0, 5'd7, 1, 8'h00, 64'd0, 1, 64'hFFFFFFFFDEADBEEF, 0);
    wait_idle;
    issue(1, 0, 2'd1, A + 6, 64'h1234, 5'd8, 1, 8'hC0, 64'h1234000000000000, 1, 64'd0, 0);
    wait_idle;
    dresp_data = 64'h8877665544332211;
    issue(0, 1, 2'd3, A + 8, 64'd0, 5'd10, 1, 8'h00, 64'd0, 1, 64'h8877665544332211, 0);
    wait_idle;

    // LW with slow bus, flushed in its second bus cycle.
    ok_delay = 3;
    issue(0, 0, 2'd2, A + 8, 64'd0, 5'd11, 1, 8'h00, 64'd0, 0, 64'd0, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!dreq_valid) break;
      cnt++;
      chk("dreq_addr_stable", dreq_addr, A + 8);
      flush = (cnt == 2);
      tick;
    end
    flush = 1'b0;
    chk("flush_bus_len", cnt, 64'd4);
    chk("flush_bus_no_resp", {63'd0, resp_valid}, 64'd0);
    chk("flush_bus_idle", {63'd0, req_ready}, 64'd1);
    tick;
    chk("flush_bus_no_resp_late", {63'd0, resp_valid}, 64'd0);
    ok_delay = 0;
    issue(1, 0, 2'd2, A + 4, 64'hCAFEBABE, 5'd12, 1, 8'hF0, 64'hCAFEBABE00000000, 1, 64'd0, 0);
    wait_idle;

    // Result held while commit stalls.
    resp_ready = 1'b0;
    dresp_data = 64'h0123456789ABCDEF;
    issue(0, 0, 2'd3, A + 16, 64'd0, 5'd13, 1, 8'h00, 64'd0, 1, 64'h0123456789ABCDEF, 0);
    for (int i = 0; i < 20 && !resp_valid; i++) tick;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_data", resp_data, 64'h0123456789ABCDEF);
      chk("hold_tag", {59'd0, resp_tag}, 64'd13);
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
      tick;
    end
    resp_ready = 1'b1;
    tick;
    chk("hold_release_idle", {63'd0, req_ready}, 64'd1);
    chk("hold_release_no_resp", {63'd0, resp_valid}, 64'd0);

    // Flush in DONE beats resp_ready; a lingering flush blocks acceptance.
    resp_ready = 1'b0;
    dresp_data = 64'h000000000000007F;
    issue(0, 0, 2'd0, A + 24, 64'd0, 5'd14, 1, 8'h00, 64'd0, 0, 64'd0, 0);
    for (int i = 0; i < 20 && !resp_valid; i++) tick;
    chk("done_reached", {63'd0, resp_valid}, 64'd1);
    flush = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("done_flush_drops", {63'd0, resp_valid}, 64'd0);
    tick;
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd3; req_addr = A; req_tag = 5'd20;
    #1;
    chk("flush_blocks_ready", {63'd0, req_ready}, 64'd0);
    tick;
    chk("flush_blocks_accept", {63'd0, dreq_valid}, 64'd0);
    chk("flush_blocks_resp", {63'd0, resp_valid}, 64'd0);
    flush = 1'b0;
    req_valid = 1'b0;
    tick;

    // Misaligned halfword load.
    dresp_data = 64'h0000000000807F00;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 0, 2'd1, A + 1, 64'd0, 5'd17, 0, 8'h00, 64'd0, 1, A + 1, 1);
    chk("trap_no_dreq", {63'd0, dreq_valid}, 64'd0);
    chk("trap_resp_now", {63'd0, resp_valid}, 64'd1);
    wait_idle;
`else
    issue(0, 0, 2'd1, A + 1, 64'd0, 5'd17, 1, 8'h00, 64'd0, 1, 64'hFFFFFFFFFFFF807F, 0);
    wait_idle;
    issue(1, 0, 2'd2, A + 6, 64'hAABBCCDD, 5'd18, 1, 8'hC0, 64'hCCDD000000000000, 1, 64'd0, 0);
    wait_idle;
`endif

    // Reset while the bus op is pending.
    ok_delay = 10;
    issue(0, 0, 2'd3, A + 32, 64'd0, 5'd15, 1, 8'h00, 64'd0, 0, 64'd0, 0);
    tick;
    tick;
    chk("pre_reset_bus", {63'd0, dreq_valid}, 64'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_reset_ready", {63'd0, req_ready}, 64'd1);
    chk("mid_reset_dreq", {63'd0, dreq_valid}, 64'd0);
    chk("mid_reset_resp", {63'd0, resp_valid}, 64'd0);
    ok_delay = 0;
    tick;
    issue(1, 0, 2'd3, A, 64'h55, 5'd16, 1, 8'hFF, 64'h55, 1, 64'd0, 0);
    wait_idle;
    repeat (3) tick;

    chk("dreq_queue_empty", dq.size(), 64'd0);
    chk("resp_queue_empty", rq.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
